// File: rtl/cdr_lock_ctrl.sv
// cdr_lock_ctrl: lock sequencer for the bit-clock recovery path (clk_200M domain).
// Define CDR_LOCK_STATS_EN to add the edge_errs bad-edge counter output.
module cdr_lock_ctrl #(
  parameter int unsigned ACQ_EDGES    = 16,
  parameter int unsigned VERIFY_EDGES = 32,
  parameter int unsigned TOL          = 2,
  parameter int unsigned MIN_PERIOD   = 4,
  parameter logic [15:0] MAX_PERIOD   = 16'd800,
  parameter int unsigned ERR_MAX      = 8,
  parameter logic [15:0] LOS_CYCLES   = 16'd4000
) (
  input  logic        clk_200M,
  input  logic        rst,
  input  logic        signal,
  input  logic [15:0] period_est,
  output logic        est_clear,
  output logic        est_freeze,
  output logic        locked,
  output logic [15:0] period_lock,
  output logic        lol,
  output logic [2:0]  state
`ifdef CDR_LOCK_STATS_EN
  ,
  output logic [15:0] edge_errs
`endif
);

  localparam int unsigned PW      = 16;
  localparam int unsigned CNT_MAX = (ACQ_EDGES > VERIFY_EDGES) ? ACQ_EDGES : VERIFY_EDGES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned EW      = $clog2(ERR_MAX + 3);
  localparam logic [PW-1:0] TOL_W = PW'(TOL);
  localparam logic [PW-1:0] MIN_W = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] SAT_W = '1;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_ACQ    = 3'd1,
    ST_VERIFY = 3'd2,
    ST_LOCKED = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sig_d;
  logic [PW-1:0] r_gap, w_gap_nxt;
  logic [PW-1:0] r_phase, w_phase_run, w_phase_nxt;
  logic [PW-1:0] r_pe_d;
  logic [PW-1:0] r_period_lock, w_period_lock_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [EW-1:0] r_err, w_err_nxt;
  logic          r_est_freeze, r_locked, r_lol, w_lol_nxt;
  logic          w_edge, w_good, w_bad, w_gap_full, w_los;

  // Edge classification uses the phase before this cycle's clear.
  assign w_edge      = signal ^ r_sig_d;
  assign w_good      = w_edge && ((r_phase <= TOL_W) || (r_phase >= r_period_lock - TOL_W));
  assign w_bad       = w_edge && !w_good;
  assign w_gap_full  = !w_edge && (r_gap == SAT_W);
  assign w_los       = !w_edge && (r_gap >= LOS_CYCLES);
  assign w_gap_nxt   = w_edge ? '0 : ((r_gap == SAT_W) ? r_gap : r_gap + PW'(1));
  assign w_phase_run = w_edge ? '0 :
                       ((r_phase == r_period_lock - PW'(1)) ? '0 : r_phase + PW'(1));

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_err_nxt         = r_err;
    w_phase_nxt       = w_phase_run;
    w_period_lock_nxt = r_period_lock;
    w_lol_nxt         = 1'b0;
    case (r_state)
      ST_CLEAR: w_state_nxt = ST_ACQ;
      ST_ACQ: begin
        if (period_est != r_pe_d) w_cnt_nxt = '0;
        else if (w_edge)          w_cnt_nxt = r_cnt + CW'(1);
        if (w_cnt_nxt == CW'(ACQ_EDGES)) begin
          if ((period_est >= MIN_W) && (period_est <= MAX_PERIOD)) begin
            w_state_nxt       = ST_VERIFY;
            w_period_lock_nxt = period_est;
            w_phase_nxt       = '0;
          end else begin
            w_state_nxt = ST_CLEAR;
          end
        end
      end
      ST_VERIFY: begin
        if (w_bad || w_gap_full) begin
          w_state_nxt = ST_CLEAR;
        end else if (w_good) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_cnt_nxt == CW'(VERIFY_EDGES)) w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_bad)                      w_err_nxt = r_err + EW'(2);
        else if (w_good && r_err != '0) w_err_nxt = r_err - EW'(1);
        // Error-score loss of lock takes priority over loss of signal.
        if (w_err_nxt >= EW'(ERR_MAX)) begin
          w_lol_nxt   = 1'b1;
          w_state_nxt = ST_CLEAR;
        end else if (w_los) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_good) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_bad || w_gap_full) begin
          w_lol_nxt   = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      w_err_nxt = '0;
    end
  end

  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      r_state       <= ST_CLEAR;
      r_sig_d       <= 1'b0;
      r_gap         <= '0;
      r_phase       <= '0;
      r_pe_d        <= '0;
      r_period_lock <= '0;
      r_cnt         <= '0;
      r_err         <= '0;
      r_est_freeze  <= 1'b0;
      r_locked      <= 1'b0;
      r_lol         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sig_d       <= signal;
      r_gap         <= w_gap_nxt;
      r_phase       <= w_phase_nxt;
      r_pe_d        <= period_est;
      r_period_lock <= w_period_lock_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err         <= w_err_nxt;
      r_est_freeze  <= (w_state_nxt == ST_VERIFY) || (w_state_nxt == ST_LOCKED) ||
                       (w_state_nxt == ST_HOLD);
      r_locked      <= (w_state_nxt == ST_LOCKED);
      r_lol         <= w_lol_nxt;
    end
  end

`ifdef CDR_LOCK_STATS_EN
  logic [PW-1:0] r_edge_errs;

  // Survives relocks; only rst clears it.
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      r_edge_errs <= '0;
    end else if (w_bad && ((r_state == ST_LOCKED) || (r_state == ST_HOLD)) &&
                 (r_edge_errs != SAT_W)) begin
      r_edge_errs <= r_edge_errs + PW'(1);
    end
  end

  assign edge_errs = r_edge_errs;
`endif

  assign est_clear   = (r_state == ST_CLEAR);
  assign est_freeze  = r_est_freeze;
  assign locked      = r_locked;
  assign period_lock = r_period_lock;
  assign lol         = r_lol;
  assign state       = r_state;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// tb_cdr_lock_ctrl: randomized scenario bench for cdr_lock_ctrl against a behavioural
// lock-sequencer model plus an estimator model; honours CDR_LOCK_STATS_EN.
module tb_cdr_lock_ctrl;

  localparam int CLR = 0, ACQ = 1, VER = 2, LCK = 3, HLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic [15:0] pe  = 16'hFFFF;
  logic        est_clear, est_freeze, locked, lol;
  logic [15:0] period_lock;
  logic [2:0]  state;
`ifdef CDR_LOCK_STATS_EN
  logic [15:0] edge_errs;
`endif

  int n_vec = 0;
  int n_err = 0;
  int est_target = 8;

  // Reference model state (plain integers, spec-level rules).
  int m_st, m_sigd, m_gap, m_phase, m_cnt, m_err, m_pe_prev, m_plock;
  int m_freeze, m_locked, m_lol, m_errs;

  cdr_lock_ctrl dut (
    .clk_200M   (clk),
    .rst        (rst),
    .signal     (sig),
    .period_est (pe),
    .est_clear  (est_clear),
    .est_freeze (est_freeze),
    .locked     (locked),
    .period_lock(period_lock),
    .lol        (lol),
    .state      (state)
`ifdef CDR_LOCK_STATS_EN
    ,
    .edge_errs  (edge_errs)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = CLR; m_sigd = 0; m_gap = 0; m_phase = 0; m_cnt = 0; m_err = 0;
    m_pe_prev = 0; m_plock = 0; m_freeze = 0; m_locked = 0; m_lol = 0; m_errs = 0;
  endtask

  task automatic model_step();
    int e, good, bad, nst, pev, quiet;
    pev   = int'(pe);
    e     = (int'(sig) != m_sigd);
    good  = e && ((m_phase <= 2) || (m_phase >= m_plock - 2));
    bad   = e && !good;
    quiet = !e;
    nst   = m_st;
    m_lol = 0;
    case (m_st)
      CLR: nst = ACQ;
      ACQ: begin
        if (pev != m_pe_prev) m_cnt = 0;
        else if (e) m_cnt = m_cnt + 1;
        if (m_cnt == 16) nst = (pev >= 4 && pev <= 800) ? VER : CLR;
      end
      VER: begin
        if (bad || (quiet && m_gap == 65535)) nst = CLR;
        else if (good) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == 32) nst = LCK;
        end
      end
      LCK: begin
        if (bad) m_err = m_err + 2;
        else if (good && m_err > 0) m_err = m_err - 1;
        if (m_err >= 8) begin nst = CLR; m_lol = 1; end
        else if (quiet && m_gap >= 4000) nst = HLD;
      end
      HLD: begin
        if (good) nst = LCK;
        else if (bad || (quiet && m_gap == 65535)) begin nst = CLR; m_lol = 1; end
      end
      default: nst = CLR;
    endcase
    if (bad && (m_st == LCK || m_st == HLD) && m_errs < 65535) m_errs = m_errs + 1;
    m_phase = e ? 0 : (m_phase + 1) % ((m_plock == 0) ? 65536 : m_plock);
    m_gap   = e ? 0 : ((m_gap < 65535) ? m_gap + 1 : 65535);
    if (m_st == ACQ && nst == VER) begin m_plock = pev; m_phase = 0; end
    if (nst != m_st) begin m_cnt = 0; m_err = 0; end
    m_freeze  = (nst == VER || nst == LCK || nst == HLD);
    m_locked  = (nst == LCK);
    m_pe_prev = pev;
    m_sigd    = int'(sig);
    m_st      = nst;
  endtask

  // One clock: model follows the DUT edge, then the estimator model reacts.
  task automatic tick();
    int old_st, old_fr, old_e;
    old_st = m_st; old_fr = m_freeze; old_e = (int'(sig) != m_sigd);
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    if (!rst) begin
      if (old_st == CLR) pe = 16'hFFFF;
      else if (old_e != 0 && old_fr == 0) pe = 16'(est_target);
    end
  endtask

  task automatic gap_edge(input int k);
    repeat (k - 1) tick();
    sig = ~sig;
    tick();
  endtask

  task automatic edge_at_phase(input int t);
    for (int i = 0; i < 40 && m_phase != t; i++) tick();
    n_vec++;
    if (m_phase != t) begin
      n_err++; $display("FAIL edge_at_phase timeout: phase %0d required %0d", m_phase, t);
    end
    sig = ~sig;
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    tick(); tick();
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", state); end
    n_vec++; if ({est_clear, est_freeze, locked, lol} !== 4'b1000) begin
      n_err++; $display("FAIL rst_flags: got %b exp 1000", {est_clear, est_freeze, locked, lol}); end
    n_vec++; if (period_lock !== 16'd0) begin n_err++; $display("FAIL rst_plock: got %0d exp 0", period_lock); end
`ifdef CDR_LOCK_STATS_EN
    n_vec++; if (edge_errs !== 16'd0) begin n_err++; $display("FAIL rst_edge_errs: got %0d exp 0", edge_errs); end
`endif
    rst = 1'b0;
    n_vec++; if (est_clear !== 1'b1) begin n_err++; $display("FAIL cycle0_est_clear: got %b exp 1", est_clear); end
    tick();
    n_vec++; if (state !== 3'd1 || est_clear !== 1'b0) begin
      n_err++; $display("FAIL clear_to_acq: state %0d est_clear %b exp 1/0", state, est_clear); end
  endtask

  task automatic test_acquire();
    int n;
    est_target = 8;
    n = 0;
    while (state != 3'd2 && n < 40) begin gap_edge(8); n++; end
    n_vec++; if (n != 17) begin n_err++; $display("FAIL acq_edges: got %0d exp 17", n); end
    n_vec++; if (period_lock !== 16'd8 || est_freeze !== 1'b1 || locked !== 1'b0) begin
      n_err++; $display("FAIL verify_entry: plock %0d frz %b lck %b exp 8/1/0", period_lock, est_freeze, locked); end
    for (int i = 1; i <= 32; i++) begin
      gap_edge(8);
      if (i == 31) begin
        n_vec++; if (state !== 3'd2 || locked !== 1'b0) begin
          n_err++; $display("FAIL verify_31: state %0d locked %b exp 2/0", state, locked); end
      end
    end
    n_vec++; if (state !== 3'd3 || locked !== 1'b1) begin
      n_err++; $display("FAIL verify_32: state %0d locked %b exp 3/1", state, locked); end
  endtask

  task automatic test_jitter();
    int jit[5];
    jit = '{0, 1, 2, 6, 7};
    for (int i = 0; i < 16; i++) begin
      edge_at_phase(jit[$urandom_range(0, 4)]);
      n_vec++; if (state !== 3'd3 || locked !== 1'b1) begin
        n_err++; $display("FAIL jitter_good: state %0d locked %b exp 3/1", state, locked); end
    end
    edge_at_phase(4);
    n_vec++; if (state !== 3'd3 || locked !== 1'b1 || lol !== 1'b0) begin
      n_err++; $display("FAIL one_bad_edge: state %0d locked %b lol %b exp 3/1/0", state, locked, lol); end
`ifdef CDR_LOCK_STATS_EN
    n_vec++; if (edge_errs !== 16'd1) begin n_err++; $display("FAIL jitter_edge_errs: got %0d exp 1", edge_errs); end
`endif
  endtask

  task automatic test_lol();
    repeat (8) edge_at_phase(7);
    for (int k = 1; k <= 4; k++) begin
      edge_at_phase(4);
      if (k < 4) begin
        n_vec++; if (state !== 3'd3 || locked !== 1'b1 || lol !== 1'b0) begin
          n_err++; $display("FAIL lol_early_%0d: state %0d locked %b lol %b exp 3/1/0", k, state, locked, lol); end
      end
    end
    n_vec++; if (state !== 3'd0 || lol !== 1'b1 || locked !== 1'b0 || est_freeze !== 1'b0 || est_clear !== 1'b1) begin
      n_err++; $display("FAIL lol_pulse: state %0d lol %b lck %b frz %b clr %b exp 0/1/0/0/1",
                        state, lol, locked, est_freeze, est_clear); end
`ifdef CDR_LOCK_STATS_EN
    n_vec++; if (edge_errs !== 16'd5) begin n_err++; $display("FAIL lol_edge_errs: got %0d exp 5", edge_errs); end
`endif
    tick();
    n_vec++; if (state !== 3'd1 || lol !== 1'b0) begin
      n_err++; $display("FAIL lol_after: state %0d lol %b exp 1/0", state, lol); end
  endtask

  task automatic test_hold();
    est_target = 8;
    for (int i = 0; i < 80 && m_st != LCK; i++) gap_edge(8);
    n_vec++; if (state !== 3'd3 || period_lock !== 16'd8) begin
      n_err++; $display("FAIL relock: state %0d plock %0d exp 3/8", state, period_lock); end
    repeat (4000) tick();
    n_vec++; if (state !== 3'd3 || locked !== 1'b1) begin
      n_err++; $display("FAIL pre_los: state %0d locked %b exp 3/1", state, locked); end
    tick();
    n_vec++; if (state !== 3'd4 || locked !== 1'b0 || est_freeze !== 1'b1 || period_lock !== 16'd8) begin
      n_err++; $display("FAIL los_hold: state %0d lck %b frz %b plock %0d exp 4/0/1/8",
                        state, locked, est_freeze, period_lock); end
    edge_at_phase(7);
    n_vec++; if (state !== 3'd3 || locked !== 1'b1) begin
      n_err++; $display("FAIL hold_relock: state %0d locked %b exp 3/1", state, locked); end
    repeat (4001) tick();
    n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL los_again: state %0d exp 4", state); end
    repeat (65535 - 4001) tick();
    n_vec++; if (state !== 3'd4 || lol !== 1'b0) begin
      n_err++; $display("FAIL pre_gap_full: state %0d lol %b exp 4/0", state, lol); end
    tick();
    n_vec++; if (state !== 3'd0 || lol !== 1'b1 || est_freeze !== 1'b0) begin
      n_err++; $display("FAIL gap_full_lol: state %0d lol %b frz %b exp 0/1/0", state, lol, est_freeze); end
    tick();
    n_vec++; if (state !== 3'd1 || lol !== 1'b0) begin
      n_err++; $display("FAIL gap_full_after: state %0d lol %b exp 1/0", state, lol); end
  endtask

  task automatic test_bad_period();
    int n;
    logic seen_lock;
    est_target = 2;
    n = 0; seen_lock = 1'b0;
    while (state != 3'd0 && n < 40) begin gap_edge(8); n++; seen_lock |= locked; end
    n_vec++; if (n != 17 || seen_lock !== 1'b0) begin
      n_err++; $display("FAIL small_period: edges %0d locked_seen %b exp 17/0", n, seen_lock); end
    tick();
    n_vec++; if (state !== 3'd1 || locked !== 1'b0) begin
      n_err++; $display("FAIL small_period_acq: state %0d locked %b exp 1/0", state, locked); end
  endtask

  task automatic test_reset_verify();
    int p;
    p = int'($urandom_range(5, 12));
    est_target = p;
    for (int i = 0; i < 40 && m_st != VER; i++) gap_edge(p);
    repeat (3) gap_edge(p);
    n_vec++; if (state !== 3'd2 || period_lock !== 16'(p)) begin
      n_err++; $display("FAIL verify_p: state %0d plock %0d exp 2/%0d", state, period_lock, p); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({state, est_clear, est_freeze, locked, lol} !== 7'b000_1000 || period_lock !== 16'd0) begin
      n_err++; $display("FAIL async_rst: state %0d flags %b plock %0d exp 0/1000/0",
                        state, {est_clear, est_freeze, locked, lol}, period_lock); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int tgt[8];
    int sp, cd, reload;
    logic [22:0] got, exp;
    tgt = '{4, 800, 801, 3, 0, 0, 0, 0};
    for (int s = 4; s < 8; s++) tgt[s] = int'($urandom_range(5, 12));
    cd = 0;
    for (int s = 0; s < 8; s++) begin
      est_target = tgt[s];
      sp = (tgt[s] >= 3 && tgt[s] <= 12) ? tgt[s] : 8;
      for (int c = 0; c < 700; c++) begin
        if (cd == 0) begin
          sig = ~sig;
          reload = sp - 1;
          if ($urandom_range(0, 11) == 0) reload = reload + int'($urandom_range(0, 6)) - 3;
          cd = (reload < 0) ? 0 : reload;
        end else begin
          cd--;
        end
        tick();
        got = {state, est_clear, est_freeze, locked, lol, period_lock};
        exp = {3'(m_st), (m_st == CLR), 1'(m_freeze), 1'(m_locked), 1'(m_lol), 16'(m_plock)};
        n_vec++; if (got !== exp) begin
          n_err++; $display("FAIL random seg%0d cyc%0d: got %h exp %h", s, c, got, exp); end
`ifdef CDR_LOCK_STATS_EN
        n_vec++; if (edge_errs !== 16'(m_errs)) begin
          n_err++; $display("FAIL random_edge_errs seg%0d cyc%0d: got %0d exp %0d", s, c, edge_errs, m_errs); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_jitter();
    test_lol();
    test_hold();
    test_bad_period();
    test_reset_verify();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
